// File: rtl/centroid_marker_ctrl_pkg.sv
// Shared widths, default image geometry and FSM encoding for the centroid marker.
package centroid_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned CNT_W     = 20;
  localparam int unsigned IMG_W_DEF = 1280;
  localparam int unsigned IMG_H_DEF = 720;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_X  = 2'd1,
    DIV_Y  = 2'd2,
    UPDATE = 2'd3
  } state_e;

endpackage

// File: rtl/centroid_marker_ctrl_seq_div.sv
// Restoring divider, one quotient bit per cycle; shared by the x and y divisions.
module seq_div
  import centroid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [ACC_W-1:0] quotient,
  output logic             done
);

  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [4:0]       step_q, step_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] rem_in;
  logic [CNT_W-1:0] dvs_in;
  logic [ACC_W-1:0] quo_in;
  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;
  logic             fits;

  // The start cycle already performs the first step, so the last bit lands 32 cycles later.
  always_comb begin
    rem_in = rem_q;
    quo_in = quo_q;
    dvs_in = dvs_q;
    if (!run_q) begin
      rem_in = '0;
      quo_in = dividend;
      dvs_in = divisor;
    end
    trial = {rem_in, quo_in[ACC_W-1]};
    diff  = trial - {1'b0, dvs_in};
    fits  = (trial >= {1'b0, dvs_in});

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    step_d = step_q;
    run_d  = run_q;
    done_d = 1'b0;

    if (run_q || start) begin
      rem_d = fits ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
      quo_d = {quo_in[ACC_W-2:0], fits};
      dvs_d = dvs_in;
      if (!run_q) begin
        run_d  = 1'b1;
        step_d = 5'd1;
      end else begin
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) begin
          run_d  = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      step_q <= step_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/centroid_marker_ctrl.sv
// Per-frame centroid of mask pixels, driving the overlay crosshair x/y inputs.
module centroid_marker_ctrl
  import centroid_pkg::*;
#(
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de,
  input  logic               v_sync,
  input  logic               mask,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               valid,
  output logic               busy,
  output logic               frame_drop
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_PIXELS);

  logic [COORD_W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [ACC_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vs_d_q;
  logic [ACC_W-1:0]   snap_y_q, snap_y_d;
  logic [CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
  state_e             state_q, state_d;
  logic [COORD_W-1:0] qx_q, qx_d;
  logic               upd_ok_q, upd_ok_d;
  logic [COORD_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic               valid_q, valid_d;

  logic               fedge;
  logic               div_start, div_done;
  logic [ACC_W-1:0]   div_dividend, div_quo;
  logic [CNT_W-1:0]   div_divisor;

  assign fedge = v_sync & ~vs_d_q;

  always_comb begin
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    if (v_sync) begin
      x_pos_d = '0;
      y_pos_d = '0;
    end else if (de) begin
      if (x_pos_q == X_LAST) begin
        x_pos_d = '0;
        y_pos_d = (y_pos_q == Y_LAST) ? '0 : y_pos_q + COORD_W'(1);
      end else begin
        x_pos_d = x_pos_q + COORD_W'(1);
      end
    end

    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    if (fedge) begin
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
    end else if (de && mask && !v_sync) begin
      sum_x_d = sum_x_q + ACC_W'(x_pos_q);
      sum_y_d = sum_y_q + ACC_W'(y_pos_q);
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // The x sum is handed to the divider in the edge cycle itself, so only y and cnt need a snapshot.
  always_comb begin
    state_d      = state_q;
    snap_y_d     = snap_y_q;
    snap_cnt_d   = snap_cnt_q;
    qx_d         = qx_q;
    upd_ok_d     = upd_ok_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    valid_d      = valid_q;
    div_start    = 1'b0;
    div_dividend = sum_x_q;
    div_divisor  = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (fedge) begin
          snap_y_d   = sum_y_q;
          snap_cnt_d = cnt_q;
          if (cnt_q >= MIN_CNT) begin
            div_start = 1'b1;
            state_d   = DIV_X;
          end else begin
            upd_ok_d = 1'b0;
            state_d  = UPDATE;
          end
        end
      end
      DIV_X: begin
        if (div_done) begin
          qx_d         = div_quo[COORD_W-1:0];
          div_start    = 1'b1;
          div_dividend = snap_y_q;
          div_divisor  = snap_cnt_q;
          state_d      = DIV_Y;
        end
      end
      DIV_Y: begin
        if (div_done) begin
          upd_ok_d = 1'b1;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        if (upd_ok_q) begin
          x_out_d = qx_q;
          y_out_d = div_quo[COORD_W-1:0];
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos_q    <= '0;
      y_pos_q    <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      cnt_q      <= '0;
      vs_d_q     <= 1'b0;
      snap_y_q   <= '0;
      snap_cnt_q <= '0;
      state_q    <= IDLE;
      qx_q       <= '0;
      upd_ok_q   <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      x_pos_q    <= x_pos_d;
      y_pos_q    <= y_pos_d;
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
      cnt_q      <= cnt_d;
      vs_d_q     <= v_sync;
      snap_y_q   <= snap_y_d;
      snap_cnt_q <= snap_cnt_d;
      state_q    <= state_d;
      qx_q       <= qx_d;
      upd_ok_q   <= upd_ok_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      valid_q    <= valid_d;
    end
  end

  seq_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quo),
    .done     (div_done)
  );

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign valid      = valid_q;
  assign busy       = (state_q != IDLE);
  assign frame_drop = fedge & (state_q != IDLE);

endmodule
